// File: rtl/divider24by12.sv
// Restoring 24/12 divider, one quotient bit per clock: result 24 edges after accept (1 edge for a zero divisor).
// No backpressure: ready is low while busy, start is ignored then, and results hold until the next accepted start.
module divider24by12 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] dividend,
    input  logic [11:0] divisor,
    output logic        ready,
    output logic        valid,
    output logic [23:0] quotient,
    output logic [11:0] remainder,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, ZERO} state_t;

    state_t      state;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [23:0] work;
    logic [11:0] dvs;
    logic [11:0] prem;
    logic [4:0]  cnt;

    logic [12:0] trial;
    logic        fits;
    logic [11:0] prem_nxt;

    // The 13-bit trial can never overflow the compare; after a subtract it is below the divisor again.
    always_comb begin
        trial    = {prem, work[23]};
        fits     = (trial >= {1'b0, dvs});
        prem_nxt = fits ? 12'(trial - {1'b0, dvs}) : trial[11:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            dvs       <= '0;
            prem      <= '0;
            cnt       <= '0;
            ready     <= 1'b1;
            valid     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work     <= dividend;
                        dvs      <= divisor;
                        prem     <= '0;
                        cnt      <= '0;
                        valid    <= 1'b0;
                        div_zero <= 1'b0;
                        ready    <= 1'b0;
                        state    <= (divisor == 12'd0) ? ZERO : BUSY;
                    end
                end
                BUSY: begin
                    prem <= prem_nxt;
                    work <= {work[22:0], fits};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd23) begin
                        quotient  <= {work[22:0], fits};
                        remainder <= prem_nxt;
                        valid     <= 1'b1;
                        ready     <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                ZERO: begin
                    quotient  <= 24'hFFFFFF;
                    remainder <= work[11:0];
                    div_zero  <= 1'b1;
                    valid     <= 1'b1;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider24by12.sv
// Directed-vector and round-trip bench for the 24/12 restoring divider.
module tb_divider24by12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] dividend;
    logic [11:0] divisor;
    logic        ready;
    logic        valid;
    logic [23:0] quotient;
    logic [11:0] remainder;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] a;
        logic [11:0] b;
        logic [23:0] q;
        logic [11:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    divider24by12 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives start for exactly one edge, then scrambles the operands.
    task automatic accept(input logic [23:0] a, input logic [11:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        chk("accept_ready", 32'(ready), 32'd0);
        chk("accept_valid", 32'(valid), 32'd0);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!valid && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [11:0] ra, rb;
        logic [23:0] p;

        vecs[0] = '{24'd1000,    12'd7,     24'd142,     12'd6,     1'b0, 24};
        vecs[1] = '{24'hFFFFFF,  12'hFFF,   24'h001001,  12'h000,   1'b0, 24};
        vecs[2] = '{24'hABCDEF,  12'h001,   24'hABCDEF,  12'h000,   1'b0, 24};
        vecs[3] = '{24'd5,       12'd9,     24'd0,       12'd5,     1'b0, 24};
        vecs[4] = '{24'h000123,  12'h000,   24'hFFFFFF,  12'h123,   1'b1, 1};
        vecs[5] = '{24'hFFFFFF,  12'h800,   24'h001FFF,  12'h7FF,   1'b0, 24};
        vecs[6] = '{24'hABC456,  12'h000,   24'hFFFFFF,  12'h456,   1'b1, 1};
        vecs[7] = '{24'h000FFF,  12'hFFF,   24'h000001,  12'h000,   1'b0, 24};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            accept(vecs[i].a, vecs[i].b);
            wait_valid(40, n);
            chk($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
            chk($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
            chk($sformatf("vec%0d_div_zero", i), 32'(div_zero), 32'(vecs[i].dz));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'd1);
        end

        // start pulse at k+10 while busy must be ignored
        accept(24'd1000, 12'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 24'd50;
        divisor  = 12'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_ready", 32'(ready), 32'd0);
        wait_valid(40, n);
        chk("busy_start_latency", 32'(n), 32'd14);
        chk("busy_start_quotient", 32'(quotient), 32'd142);
        chk("busy_start_remainder", 32'(remainder), 32'd6);

        // back-to-back: start on edge k+25 is accepted and valid drops
        start    = 1'b1;
        dividend = 24'd100000;
        divisor  = 12'd123;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        chk("b2b_valid_drop", 32'(valid), 32'd0);
        chk("b2b_ready_drop", 32'(ready), 32'd0);
        wait_valid(40, n);
        chk("b2b_latency", 32'(n), 32'd24);
        chk("b2b_quotient", 32'(quotient), 32'd813);
        chk("b2b_remainder", 32'(remainder), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_quotient", 32'(quotient), 32'd813);
        chk("hold_remainder", 32'(remainder), 32'd1);

        // asynchronous reset in the middle of a division
        accept(24'd777777, 12'd1000);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_valid", 32'(valid), 32'd0);
        accept(24'd777777, 12'd1000);
        wait_valid(40, n);
        chk("postrst_latency", 32'(n), 32'd24);
        chk("postrst_quotient", 32'(quotient), 32'd777);
        chk("postrst_remainder", 32'(remainder), 32'd777);

        // round trip through a 12x12 product
        for (int t = 0; t < 1000; t++) begin
            ra = 12'($urandom_range(0, 4095));
            rb = 12'($urandom_range(1, 4095));
            p  = {12'd0, ra} * {12'd0, rb};
            accept(p, rb);
            wait_valid(40, n);
            chk("rt_quotient", 32'(quotient), 32'(ra));
            chk("rt_remainder", 32'(remainder), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
